// File: rtl/sm_para_sched.sv
// Round-robin scheduler sharing one sm_para-style FSM between two requesters.
// Grants bounded bursts and resets the FSM through fsm_nrst after an err abort.
module sm_para_sched #(
    parameter int unsigned LW      = 4,
    parameter int unsigned RST_CYC = 2
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          req0,
    input  logic          req1,
    input  logic [LW-1:0] len0,
    input  logic [LW-1:0] len1,
    input  logic [1:0]    d0,
    input  logic [1:0]    d1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          done0,
    output logic          done1,
    output logic          err0,
    output logic          err1,
    output logic          fsm_i1,
    output logic          fsm_i2,
    output logic          fsm_nrst,
    input  logic          fsm_err,
    output logic [7:0]    err_cnt
);

    localparam int unsigned RW = (RST_CYC < 2) ? 1 : $clog2(RST_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BURST,
        S_RECOVER,
        S_GAP
    } state_t;

    state_t        r_state, w_state_nxt;
    logic          r_gnt0, w_gnt0_nxt;
    logic          r_gnt1, w_gnt1_nxt;
    logic          r_done0, w_done0_nxt;
    logic          r_done1, w_done1_nxt;
    logic          r_err0, w_err0_nxt;
    logic          r_err1, w_err1_nxt;
    logic          r_fsm_nrst, w_fsm_nrst_nxt;
    logic [7:0]    r_err_cnt, w_err_cnt_nxt;
    logic          r_last, w_last_nxt;
    logic          r_sel, w_sel_nxt;
    logic [LW-1:0] r_cnt, w_cnt_nxt;
    logic [RW-1:0] r_rcnt, w_rcnt_nxt;

    logic          w_pick1;
    logic [LW-1:0] w_len_sel;
    logic [LW-1:0] w_len_eff;
    logic          w_req_sel;

    // On a tie requester 1 wins only when requester 0 was served last.
    assign w_pick1   = req1 & (~req0 | ~r_last);
    assign w_len_sel = w_pick1 ? len1 : len0;
    assign w_len_eff = (w_len_sel == '0) ? LW'(1) : w_len_sel;
    assign w_req_sel = r_sel ? req1 : req0;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state    <= S_IDLE;
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_done0    <= 1'b0;
            r_done1    <= 1'b0;
            r_err0     <= 1'b0;
            r_err1     <= 1'b0;
            r_fsm_nrst <= 1'b1;
            r_err_cnt  <= '0;
            r_last     <= 1'b1;
            r_sel      <= 1'b0;
            r_cnt      <= '0;
            r_rcnt     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt0     <= w_gnt0_nxt;
            r_gnt1     <= w_gnt1_nxt;
            r_done0    <= w_done0_nxt;
            r_done1    <= w_done1_nxt;
            r_err0     <= w_err0_nxt;
            r_err1     <= w_err1_nxt;
            r_fsm_nrst <= w_fsm_nrst_nxt;
            r_err_cnt  <= w_err_cnt_nxt;
            r_last     <= w_last_nxt;
            r_sel      <= w_sel_nxt;
            r_cnt      <= w_cnt_nxt;
            r_rcnt     <= w_rcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_gnt0_nxt     = r_gnt0;
        w_gnt1_nxt     = r_gnt1;
        w_done0_nxt    = 1'b0;
        w_done1_nxt    = 1'b0;
        w_err0_nxt     = 1'b0;
        w_err1_nxt     = 1'b0;
        w_fsm_nrst_nxt = r_fsm_nrst;
        w_err_cnt_nxt  = r_err_cnt;
        w_last_nxt     = r_last;
        w_sel_nxt      = r_sel;
        w_cnt_nxt      = r_cnt;
        w_rcnt_nxt     = r_rcnt;

        case (r_state)
            S_IDLE: begin
                if (req0 | req1) begin
                    w_sel_nxt   = w_pick1;
                    w_cnt_nxt   = w_len_eff;
                    w_gnt0_nxt  = ~w_pick1;
                    w_gnt1_nxt  = w_pick1;
                    w_state_nxt = S_BURST;
                end
            end
            S_BURST: begin
                if (fsm_err) begin
                    w_gnt0_nxt     = 1'b0;
                    w_gnt1_nxt     = 1'b0;
                    w_err0_nxt     = ~r_sel;
                    w_err1_nxt     = r_sel;
                    w_err_cnt_nxt  = (r_err_cnt != 8'hFF) ? r_err_cnt + 8'd1 : r_err_cnt;
                    w_fsm_nrst_nxt = 1'b0;
                    w_rcnt_nxt     = RW'(RST_CYC);
                    w_state_nxt    = S_RECOVER;
                end else if (!w_req_sel) begin
                    w_gnt0_nxt  = 1'b0;
                    w_gnt1_nxt  = 1'b0;
                    w_state_nxt = S_GAP;
                end else if (r_cnt == LW'(1)) begin
                    w_gnt0_nxt  = 1'b0;
                    w_gnt1_nxt  = 1'b0;
                    w_done0_nxt = ~r_sel;
                    w_done1_nxt = r_sel;
                    w_state_nxt = S_GAP;
                end else begin
                    w_cnt_nxt = r_cnt - LW'(1);
                end
            end
            S_RECOVER: begin
                if (r_rcnt == RW'(1)) begin
                    w_fsm_nrst_nxt = 1'b1;
                    w_state_nxt    = S_GAP;
                end else begin
                    w_rcnt_nxt = r_rcnt - RW'(1);
                end
            end
            S_GAP: begin
                w_last_nxt  = r_sel;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign gnt0     = r_gnt0;
    assign gnt1     = r_gnt1;
    assign done0    = r_done0;
    assign done1    = r_done1;
    assign err0     = r_err0;
    assign err1     = r_err1;
    assign fsm_nrst = r_fsm_nrst;
    assign err_cnt  = r_err_cnt;

    // Stimulus mux follows the registered grants so fsm_i is 00 outside a burst.
    assign fsm_i1 = (r_gnt0 & d0[1]) | (r_gnt1 & d1[1]);
    assign fsm_i2 = (r_gnt0 & d0[0]) | (r_gnt1 & d1[0]);

endmodule

// File: doc/sm_para_sched.md
Name: sm_para_sched

Overview:
- Round-robin scheduler that shares one sm_para-style FSM instance between two requesters.
- The FSM instance has inputs i1, i2 and an active-low reset, and outputs o1, o2, err.
- The scheduler grants the FSM input pair (i1, i2) to one requester at a time for a bounded burst of cycles.
- It watches the FSM err output, and on error it pulses the FSM reset before the FSM is reused.

Parameters:
- LW, 4: width of burst-length inputs and the internal burst counter.
- RST_CYC, 2: number of cycles fsm_nrst is held low during error recovery (≥1).

Ports:
- clk  input  1  system clock; rising edge active.
- nrst  input  1  asynchronous active-low reset.
- req0  input  1  requester 0 wants the FSM; level, held for the whole burst.
- req1  input  1  requester 1 wants the FSM.
- len0  input  LW  requester 0 burst length in cycles; sampled at grant; 0 is treated as 1.
- len1  input  LW  requester 1 burst length in cycles.
- d0  input  2  requester 0 stimulus {i1,i2}.
- d1  input  2  requester 1 stimulus {i1,i2}.
- gnt0  output  1  requester 0 owns the FSM this cycle.
- gnt1  output  1  requester 1 owns the FSM this cycle.
- done0  output  1  one-cycle pulse: requester 0 burst completed without error.
- done1  output  1  one-cycle pulse: requester 1 burst completed without error.
- err0  output  1  one-cycle pulse: requester 0 burst aborted by FSM err.
- err1  output  1  one-cycle pulse: requester 1 burst aborted by FSM err.
- fsm_i1  output  1  drives FSM i1.
- fsm_i2  output  1  drives FSM i2.
- fsm_nrst  output  1  drives FSM reset; registered, active-low.
- fsm_err  input  1  FSM err output.
- err_cnt  output  8  saturating count of error aborts.

Behaviour:
- Reset (nrst=0, asynchronous):
  - state=IDLE, gnt0=gnt1=0, all pulses 0.
  - fsm_i1=fsm_i2=0, fsm_nrst=1, err_cnt=0.
  - last-served pointer=1, so req0 wins the first tie.
  - Reset mid-burst aborts silently: no done or err pulse.
- States: IDLE, BURST, RECOVER, GAP. All outputs are registered except fsm_i1/fsm_i2.
- fsm_{i1,i2} = d0 when gnt0, d1 when gnt1, else 2'b00. This mux is combinational from the registered grants.
- IDLE:
  - If req0 or req1 is sampled high: select the requester (if both, the one not equal to last), load cnt=max(len_sel,1), set gnt_sel, go BURST.
  - Otherwise stay. gnt rises one cycle after req is sampled.
- BURST, evaluated each edge in this priority:
  1. fsm_err=1:
     - clear gnt, pulse err_sel, err_cnt+=1 (saturates at 255).
     - fsm_nrst<=0, rcnt=RST_CYC, go RECOVER.
  2. req_sel=0 (withdrawn):
     - clear gnt, no pulse, go GAP.
  3. cnt==1:
     - clear gnt, pulse done_sel, go GAP.
  4. Otherwise: cnt-=1.
- The burst therefore owns the FSM for exactly max(len,1) cycles when there is no error or withdrawal.
- RECOVER:
  - fsm_nrst stays low for RST_CYC cycles (rcnt decrements); fsm_i=00.
  - When rcnt==1: fsm_nrst<=1, go GAP.
- GAP:
  - One cycle with fsm_i=00 and no grant; last<=sel; go IDLE.
  - The next grant's gnt therefore rises at the earliest 2 cycles after the previous gnt fell.
- Pointer semantics:
  - last updates only in GAP, and only after a grant.
  - A requester still asserting req after its own burst loses to the other requester if that one is asserted.
- Other requester:
  - Changes on the non-granted requester's req/len/d during a burst are ignored.
  - Its pulses stay 0.
- Invariants:
  - gnt0 and gnt1 are never both 1.
  - done and err are never both pulsed for the same burst.
  - fsm_err is ignored outside BURST.

Test Plan:
1. Single requester, no error: req0=1, len0=3, d0=2'b10, fsm_err=0.
   - gnt0 high for exactly 3 cycles; fsm_i1=1, fsm_i2=0 during those cycles.
   - done0 pulses on the cycle gnt0 falls.
   - gnt0 rises again 2 cycles later.
2. Tie and round-robin: req0=req1=1, len0=2, len1=1.
   - After reset the grant order is gnt0 (2 cycles), gap, gnt1 (1 cycle), gap, gnt0.
   - done0 and done1 pulse accordingly.
3. Error abort: req1 only, len1=5, fsm_err forced to 1 on the 2nd grant cycle.
   - gnt1 falls after 2 cycles; err1 pulses and err_cnt=1.
   - fsm_nrst is low for exactly 2 cycles, then 1 GAP cycle, then re-grant.
   - No done1 pulse.
4. Withdrawal: req0 dropped on the 2nd cycle of a len0=4 burst.
   - gnt0 falls; neither done0 nor err0 pulses; GAP follows.
   - A pending req1 is granted next.
5. Length zero and reset mid-burst: len0=0 gives a 1-cycle grant with done0.
   - Asserting nrst=0 mid-burst of len0=6 immediately clears gnt0 with no pulses and fsm_nrst=1.
   - After release, req0 wins a tie against req1.
6. Saturation: force 260 error aborts; err_cnt holds at 255.
